// File: rtl/debug_slave_cmd_engine.sv
// rtl/debug_slave_cmd_engine.sv - virtual-JTAG command capture, FIFO and per-channel action pulses
module debug_slave_cmd_engine #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int ACT_BIT     = SR_W - 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [SR_W-1:0]          sr,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic                     cmd_ready,
  input  logic                     overflow_clr,
  output logic                     cmd_valid,
  output logic [SR_W-1:0]          jdo,
  output logic [IR_W-1:0]          cmd_ir,
  output logic [N_CH-1:0]          take_action,
  output logic [N_CH-1:0]          take_no_action,
  output logic                     ir_strobe,
  output logic                     bad_ir,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = IR_W + SR_W;
  localparam int CNT_W = $clog2(SYNC_STAGES + 2);

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       warm_cnt_q, warm_cnt_d;
  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
  logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
  logic                   udr_hist_q, udr_hist_d;
  logic                   uir_hist_q, uir_hist_d;
  logic                   udr_evt_q, udr_evt_d;
  logic                   ir_strobe_q, ir_strobe_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [N_CH-1:0]        take_action_q, take_action_d;
  logic [N_CH-1:0]        take_no_action_q, take_no_action_d;
  logic                   bad_ir_q, bad_ir_d;
  logic                   overflow_q, overflow_d;
  logic [ENT_W-1:0]       mem_q [DEPTH];
  logic [ENT_W-1:0]       mem_d [DEPTH];

  logic             udr_rise;
  logic             uir_rise;
  logic             run;
  logic             push;
  logic             pop;
  logic             full;
  logic             accept;
  logic             drop;
  logic             ch_hit;
  logic [ENT_W-1:0] head;
  logic [IR_W-1:0]  head_ir;
  logic             head_act;

  assign head      = mem_q[rptr_q];
  assign head_ir   = head[ENT_W-1:SR_W];
  assign head_act  = head[ACT_BIT];
  assign cmd_valid = (level_q != '0);

  always_comb begin
    state_d          = state_q;
    warm_cnt_d       = warm_cnt_q;
    udr_sync_d       = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_sync_d       = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    udr_hist_d       = udr_sync_q[SYNC_STAGES-1];
    uir_hist_d       = uir_sync_q[SYNC_STAGES-1];
    wptr_d           = wptr_q;
    rptr_d           = rptr_q;
    level_d          = level_q;
    mem_d            = mem_q;
    take_action_d    = '0;
    take_no_action_d = '0;
    bad_ir_d         = 1'b0;
    overflow_d       = overflow_q;
    ch_hit           = 1'b0;

    // Hold off edge detection until the synchroniser and history flops carry real samples.
    case (state_q)
      WARM: begin
        warm_cnt_d = warm_cnt_q + CNT_W'(1);
        if (warm_cnt_q == CNT_W'(SYNC_STAGES)) begin
          state_d = RUN;
        end
      end
      RUN: ;
      default: state_d = WARM;
    endcase

    run         = (state_q == RUN);
    udr_rise    = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;
    uir_rise    = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;
    udr_evt_d   = run & udr_rise;
    ir_strobe_d = run & uir_rise;

    push   = udr_evt_q;
    pop    = cmd_valid & cmd_ready;
    full   = (level_q == LVL_W'(DEPTH));
    accept = push & (~full | pop);
    drop   = push & full & ~pop;

    if (accept) begin
      mem_d[wptr_q] = {ir_in, sr};
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({accept, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (pop) begin
      for (int i = 0; i < N_CH; i++) begin
        if (head_ir == IR_W'(i)) begin
          ch_hit              = 1'b1;
          take_action_d[i]    = head_act;
          take_no_action_d[i] = ~head_act;
        end
      end
      bad_ir_d = ~ch_hit;
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (overflow_clr) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= WARM;
      warm_cnt_q       <= '0;
      udr_sync_q       <= '0;
      uir_sync_q       <= '0;
      udr_hist_q       <= 1'b0;
      uir_hist_q       <= 1'b0;
      udr_evt_q        <= 1'b0;
      ir_strobe_q      <= 1'b0;
      wptr_q           <= '0;
      rptr_q           <= '0;
      level_q          <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      bad_ir_q         <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      warm_cnt_q       <= warm_cnt_d;
      udr_sync_q       <= udr_sync_d;
      uir_sync_q       <= uir_sync_d;
      udr_hist_q       <= udr_hist_d;
      uir_hist_q       <= uir_hist_d;
      udr_evt_q        <= udr_evt_d;
      ir_strobe_q      <= ir_strobe_d;
      wptr_q           <= wptr_d;
      rptr_q           <= rptr_d;
      level_q          <= level_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      bad_ir_q         <= bad_ir_d;
      overflow_q       <= overflow_d;
    end
  end

  // Storage is only observable through the valid-gated outputs, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign jdo            = cmd_valid ? head[SR_W-1:0] : '0;
  assign cmd_ir         = cmd_valid ? head_ir : '0;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign ir_strobe      = ir_strobe_q;
  assign bad_ir         = bad_ir_q;
  assign overflow       = overflow_q;
  assign level          = level_q;

endmodule
